branch_predictor: RTL



---
 rtl/branch_predictor.sv | 102 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Bimodal predictor: 2-bit saturating counters indexed by low PC bits,
// registered lookup, execute-stage training and saturating debug statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int PC_WIDTH   = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lk_valid,
  input  logic [PC_WIDTH-1:0] lk_pc,
  input  logic                flush,
  output logic                pred_valid,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                upd_miss,
  output logic [15:0]         branch_cnt,
  output logic [15:0]         miss_cnt
);

  localparam int          c_entries  = 1 << INDEX_BITS;
  localparam logic [1:0]  c_weak_nt  = 2'b01;
  localparam logic [15:0] c_cnt_max  = 16'hFFFF;

  logic [1:0]            r_table [c_entries];
  logic                  r_pred_valid;
  logic                  r_pred_taken;
  logic [15:0]           r_branch_cnt;
  logic [15:0]           r_miss_cnt;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic                  w_act;
  logic [1:0]            w_upd_old;
  logic [1:0]            w_upd_new;
  logic                  w_unused_pc;

  assign w_lk_idx    = lk_pc[INDEX_BITS-1:0];
  assign w_upd_idx   = upd_pc[INDEX_BITS-1:0];
  assign w_unused_pc = ^{lk_pc[PC_WIDTH-1:INDEX_BITS], upd_pc[PC_WIDTH-1:INDEX_BITS]};

  // The checker reports the guess it used and whether it was wrong;
  // their XOR is the real direction.
  assign w_act     = upd_taken ^ upd_miss;
  assign w_upd_old = r_table[w_upd_idx];

  always_comb begin
    w_upd_new = w_upd_old;
    if (w_act) begin
      if (w_upd_old != 2'b11) w_upd_new = w_upd_old + 2'd1;
    end else begin
      if (w_upd_old != 2'b00) w_upd_new = w_upd_old - 2'd1;
    end
  end

  // Lookup reads the pre-edge table, so a same-index update this cycle
  // is only seen by the following lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < c_entries; e++) r_table[e] <= c_weak_nt;
    end else if (upd_valid) begin
      r_table[w_upd_idx] <= w_upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else if (lk_valid && !flush) begin
      r_pred_valid <= 1'b1;
      r_pred_taken <= r_table[w_lk_idx][1];
    end else begin
      r_pred_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= 16'd0;
      r_miss_cnt   <= 16'd0;
    end else if (upd_valid) begin
      if (r_branch_cnt != c_cnt_max) r_branch_cnt <= r_branch_cnt + 16'd1;
      if (upd_miss && (r_miss_cnt != c_cnt_max)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign branch_cnt = r_branch_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

`default_nettype wire
